// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns loads/stores into a mreq/mready/mvalid memory
// transaction and stalls the pipeline until it finishes or times out.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        err,
  output logic        mreq,
  output logic        mwe,
  output logic [15:0] maddr,
  output logic [15:0] mwdata,
  input  logic        mready,
  input  logic        mvalid,
  input  logic [15:0] mrdata
);

  // state | meaning
  // IDLE  | waiting for a load/store; latches address/data when one appears
  // REQ   | mreq high, waiting for mready
  // WAIT  | request accepted, waiting for mvalid
  // DONE  | stall released for one cycle, pipeline advances
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] maddr_q, maddr_d;
  logic [15:0] mwdata_q, mwdata_d;
  logic        err_q, err_d;
  logic        mreq_q, mreq_d;
  logic        mwe_q, mwe_d;
  logic        op_valid;
  logic        timeout;

  assign op_valid = mem_read | mem_write;
  assign timeout  = (cnt_q == CNT_TC);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    err_d    = err_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          state_d  = S_REQ;
          cnt_d    = 8'd0;
          maddr_d  = addr;
          mwdata_d = wdata;
          mwe_d    = mem_write;
          mreq_d   = 1'b1;
          if (mem_read && mem_write) err_d = 1'b1;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // a stuck request times out even if mready shows up on the last cycle
        if (timeout) begin
          state_d = S_DONE;
          mreq_d  = 1'b0;
          err_d   = 1'b1;
          rdata_d = 16'h0000;
        end else if (mready) begin
          state_d = S_WAIT;
          mreq_d  = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mvalid) begin
          state_d = S_DONE;
          if (!mwe_q) rdata_d = mrdata;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 16'h0000;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rdata_q  <= 16'h0000;
      maddr_q  <= 16'h0000;
      mwdata_q <= 16'h0000;
      err_q    <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      err_q    <= err_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
    end
  end

  assign stall = rst & ((state_q == S_REQ) | (state_q == S_WAIT) |
                        ((state_q == S_IDLE) & op_valid));

  assign rdata_out = rdata_q;
  assign err       = err_q;
  assign mreq      = mreq_q;
  assign mwe       = mwe_q;
  assign maddr     = maddr_q;
  assign mwdata    = mwdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random transactions
// checked against a latency/timeout arithmetic model.
module tb_mem_stage_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, mready, mvalid;
  logic [15:0] addr, wdata, mrdata;
  logic        stall, err, mreq, mwe;
  logic [15:0] rdata_out, maddr, mwdata;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl_rdata;
  logic        mdl_err;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
    .err(err), .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mready(mready), .mvalid(mvalid), .mrdata(mrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; mready = 1'b0; mvalid = 1'b0;
      #1;
      check("idle_stall", 32'(stall), 32'(0));
      check("idle_mreq", 32'(mreq), 32'(0));
      check("idle_err", 32'(err), 32'(mdl_err));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mready = 1'b1; mvalid = 1'b1;
    #1;
    check("rst_stall_forced", 32'(stall), 32'(0));
    @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_mreq", 32'(mreq), 32'(0));
    check("rst_mwe", 32'(mwe), 32'(0));
    check("rst_maddr", 32'(maddr), 32'(0));
    check("rst_mwdata", 32'(mwdata), 32'(0));
    check("rst_rdata", 32'(rdata_out), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mready = 1'b0; mvalid = 1'b0;
    mdl_rdata = 16'h0000;
    mdl_err = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'(0));
  endtask

  // r: REQ cycles before mready; v: WAIT cycles before mvalid.
  task automatic run_op(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] md,
                        input int r, input int v, input string tag);
    bit comp, done;
    int exp_stall, exp_mreq, nmreq, first_mreq, stall_cycles;
    // Completion requires mvalid no later than REQ/WAIT cycle TO-1.
    comp       = (r + v + 1 <= TO - 1);
    exp_stall  = comp ? r + v + 3 : TO + 1;
    exp_mreq   = (r + 1 < TO) ? r + 1 : TO;
    nmreq      = 0;
    first_mreq = -1;
    stall_cycles = 0;
    done       = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      mready = (c == 1 + r);
      mvalid = (c == 2 + r + v);
      mrdata = mvalid ? md : 16'($urandom);
      #1;
      if (c == 0) check({tag, "_stall_first"}, 32'(stall), 32'(1));
      if (mreq) begin
        nmreq++;
        if (first_mreq < 0) first_mreq = c;
        check({tag, "_mwe"}, 32'(mwe), 32'(wr));
        check({tag, "_maddr"}, 32'(maddr), 32'(a));
        check({tag, "_mwdata"}, 32'(mwdata), 32'(d));
      end
      if (c > 0 && !stall) begin
        done = 1'b1;
        stall_cycles = c;
      end
    end
    check({tag, "_completed"}, 32'(done), 32'(1));
    if (rd && wr) mdl_err = 1'b1;
    if (!comp) begin
      mdl_err   = 1'b1;
      mdl_rdata = 16'h0000;
    end else if (!wr) begin
      mdl_rdata = md;
    end
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    check({tag, "_mreq_cycles"}, 32'(nmreq), 32'(exp_mreq));
    check({tag, "_mreq_start"}, 32'(first_mreq), 32'(1));
    check({tag, "_done_mreq"}, 32'(mreq), 32'(0));
    check({tag, "_rdata"}, 32'(rdata_out), 32'(mdl_rdata));
    check({tag, "_err"}, 32'(err), 32'(mdl_err));
  endtask

  initial begin
    bit          rd, wr;
    int          sel;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mready = 1'b0; mvalid = 1'b0;
    addr = 16'h0; wdata = 16'h0; mrdata = 16'h0;
    mdl_rdata = 16'h0; mdl_err = 1'b0;

    do_reset();
    idle(2);

    run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, "load");
    idle(1);
    run_op(1'b0, 1'b1, 16'h0010, 16'h1234, 16'hFFFF, 3, 1, "store");
    idle(1);
    run_op(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0001, 0, 0, "b2b_first");
    run_op(1'b1, 1'b0, 16'h0101, 16'h0000, 16'h0002, 1, 0, "b2b_second");
    idle(1);
    run_op(1'b1, 1'b1, 16'h0020, 16'h5555, 16'h7777, 0, 0, "illegal");
    idle(1);

    // reset while the memory is still working on a load
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 16'h0050; mready = 1'b0; mvalid = 1'b0;
    @(negedge clk);
    mready = 1'b1;
    #1;
    check("rstw_mreq", 32'(mreq), 32'(1));
    @(negedge clk);
    mready = 1'b0; rst = 1'b0;
    #1;
    check("rstw_stall_forced", 32'(stall), 32'(0));
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mvalid = 1'b1; mrdata = 16'hDEAD;
    mdl_rdata = 16'h0000; mdl_err = 1'b0;
    #1;
    check("rstw_stall", 32'(stall), 32'(0));
    check("rstw_mreq_low", 32'(mreq), 32'(0));
    @(negedge clk);
    mvalid = 1'b0;
    #1;
    check("rstw_rdata", 32'(rdata_out), 32'(0));
    check("rstw_err", 32'(err), 32'(0));
    check("rstw_idle_stall", 32'(stall), 32'(0));
    idle(1);

    run_op(1'b1, 1'b0, 16'h0060, 16'h0000, 16'h1111, 2, 2, "pre_timeout");
    run_op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'hAAAA, 0, 100, "timeout");
    idle(20);

    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 9) do_reset();
      idle($urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 5);
      wr = (sel <= 4);
      run_op(rd, wr, 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 7), $urandom_range(0, 7), "rand");
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
